// File: rtl/sprite_mixer.sv
// rtl/sprite_mixer.sv - sprite priority/transparency mixer with per-sprite palette and collision capture
//
// Purpose:
//   Merges the registered pix/drawing outputs of NSPR sprite line renderers.
//   Stage 1 resolves transparency and fixed priority (sprite 0 highest).
//   Stage 2 looks the winning index up in a writable per-sprite palette and
//   drives RGB 4:4:4. de/hsync/vsync travel alongside, so every output lags
//   its input pixel by exactly two cycles. Overlaps between sprite 0 (the
//   player) and every other sprite are accumulated over a frame and reported
//   at the next frame pulse.
//
// Optional feature (macro MIXER_COLL_STICKY_EN):
//   Adds coll_clr / coll_sticky, a set-dominant sticky copy of every counted
//   collision that holds until software clears it.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   frame              start-of-frame pulse; closes the collision window
//   de, hsync, vsync   display timing, aligned with the renderer outputs
//   drawing[NSPR]      per-sprite drawing flag
//   pix[NSPR*SPR_DATAW] per-sprite pixel index, sprite i at [i*SPR_DATAW +: SPR_DATAW]
//   pal_we/addr/data   palette write port, address {sprite, index}, data {R,G,B}
//   r, g, b            colour output, 4 bits each
//   de_o, hsync_o, vsync_o timing realigned to the colour output
//   coll[NSPR]         collisions of the previous frame; bit 0 always 0
//   coll_valid         one-cycle pulse when coll updates
//   coll_clr           (optional) clears coll_sticky
//   coll_sticky[NSPR]  (optional) sticky collision flags

module sprite_mixer #(
    parameter int          NSPR       = 4,
    parameter int          SPR_DATAW  = 3,
    parameter int          TRANSP_IDX = 0,
    parameter logic [11:0] BG_COLR    = 12'h137
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame,
    input  logic                             de,
    input  logic                             hsync,
    input  logic                             vsync,
    input  logic [NSPR-1:0]                  drawing,
    input  logic [NSPR*SPR_DATAW-1:0]        pix,
    input  logic                             pal_we,
    input  logic [$clog2(NSPR)+SPR_DATAW-1:0] pal_addr,
    input  logic [11:0]                      pal_data,
`ifdef MIXER_COLL_STICKY_EN
    input  logic                             coll_clr,
    output logic [NSPR-1:0]                  coll_sticky,
`endif
    output logic [3:0]                       r,
    output logic [3:0]                       g,
    output logic [3:0]                       b,
    output logic                             de_o,
    output logic                             hsync_o,
    output logic                             vsync_o,
    output logic [NSPR-1:0]                  coll,
    output logic                             coll_valid
);

    localparam int SELW = $clog2(NSPR);
    localparam int PAW  = SELW + SPR_DATAW;
    // Sized to the full address space so {sel, idx} always indexes in range.
    localparam int NENT = 1 << PAW;
    localparam logic [SPR_DATAW-1:0] TRANSP = TRANSP_IDX[SPR_DATAW-1:0];

    // ------------------------------------------------------------------
    // Palette
    // ------------------------------------------------------------------
    logic [11:0] pal_q [NENT];
    logic        pal_wr_ok;

    // Sprite fields beyond NSPR-1 are only reachable for non power-of-two
    // NSPR; such writes are dropped rather than aliased.
    assign pal_wr_ok = pal_we && (int'(pal_addr[PAW-1:SPR_DATAW]) < NSPR);

    // The stage-2 read below samples pal_q before this write lands, so a
    // same-cycle write/read returns the old colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NENT; e++) begin
                pal_q[e] <= '0;
            end
        end else if (pal_wr_ok) begin
            pal_q[pal_addr] <= pal_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: opacity, priority, timing delay
    // ------------------------------------------------------------------
    logic [NSPR-1:0]      opaque;
    logic                 hit1_d, hit1_q;
    logic [SELW-1:0]      sel1_d, sel1_q;
    logic [SPR_DATAW-1:0] idx1_d, idx1_q;
    logic                 de1_q, hs1_q, vs1_q;

    always_comb begin
        opaque = '0;
        for (int i = 0; i < NSPR; i++) begin
            opaque[i] = drawing[i] && (pix[i*SPR_DATAW +: SPR_DATAW] != TRANSP);
        end
        hit1_d = |opaque;
        sel1_d = '0;
        idx1_d = '0;
        // Walk from lowest priority up so the lowest opaque index wins last.
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                sel1_d = SELW'(i);
                idx1_d = pix[i*SPR_DATAW +: SPR_DATAW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit1_q <= 1'b0;
            sel1_q <= '0;
            idx1_q <= '0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
        end else begin
            hit1_q <= hit1_d;
            sel1_q <= sel1_d;
            idx1_q <= idx1_d;
            de1_q  <= de;
            hs1_q  <= hsync;
            vs1_q  <= vsync;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: palette lookup, background, blanking
    // ------------------------------------------------------------------
    logic [11:0]  rgb2_d, rgb2_q;
    logic [PAW-1:0] rd_addr;
    logic         de2_q, hs2_q, vs2_q;

    assign rd_addr = {sel1_q, idx1_q};

    always_comb begin
        rgb2_d = '0;
        if (de1_q) begin
            rgb2_d = hit1_q ? pal_q[rd_addr] : BG_COLR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb2_q <= '0;
            de2_q  <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
        end else begin
            rgb2_q <= rgb2_d;
            de2_q  <= de1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
        end
    end

    assign r       = rgb2_q[11:8];
    assign g       = rgb2_q[7:4];
    assign b       = rgb2_q[3:0];
    assign de_o    = de2_q;
    assign hsync_o = hs2_q;
    assign vsync_o = vs2_q;

    // ------------------------------------------------------------------
    // Collision accumulation
    // ------------------------------------------------------------------
    logic [NSPR-1:0] hits;
    logic [NSPR-1:0] acc_d, acc_q;
    logic [NSPR-1:0] coll_d, coll_q;
    logic            coll_valid_d, coll_valid_q;

    // Bit 0 would be the player against itself, so it is held at 0.
    always_comb begin
        hits = '0;
        if (de) begin
            hits = {opaque[NSPR-1:1] & {(NSPR-1){opaque[0]}}, 1'b0};
        end
    end

    always_comb begin
        acc_d        = acc_q | hits;
        coll_d       = coll_q;
        coll_valid_d = 1'b0;
        if (frame) begin
            // A hit on the frame cycle still belongs to the closing frame.
            coll_d       = acc_q | hits;
            acc_d        = '0;
            coll_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            coll_q       <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            coll_q       <= coll_d;
            coll_valid_q <= coll_valid_d;
        end
    end

    assign coll       = coll_q;
    assign coll_valid = coll_valid_q;

`ifdef MIXER_COLL_STICKY_EN
    // ------------------------------------------------------------------
    // Sticky collision flags; a new hit beats a simultaneous clear.
    // ------------------------------------------------------------------
    logic [NSPR-1:0] sticky_d, sticky_q;

    always_comb begin
        sticky_d = (coll_clr ? '0 : sticky_q) | hits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign coll_sticky = sticky_q;
`endif

endmodule

// File: doc/sprite_mixer.md
Name: sprite_mixer

Overview:
Downstream consumer of the per-sprite line renderers. Takes each renderer's registered pix/drawing pair plus the display timing signals. Resolves per-pixel priority and transparency, maps the winning pixel index through a writable per-sprite palette, and drives 4:4:4 RGB with timing realigned to the colour pipeline. Also accumulates per-frame collisions between sprite 0 (the player) and every other sprite for the game logic.

Parameters:
NSPR, 4, number of sprite inputs (2..8); index 0 is highest priority and is the player.
SPR_DATAW, 3, bits per sprite pixel, matching the renderer's data width.
TRANSP_IDX, 0, pixel index treated as transparent.
BG_COLR, 12'h137, background colour {R,G,B}, 4 bits each.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
frame  in  1  start-of-frame pulse, 1 cycle
de  in  1  display enable, aligned with the renderer outputs
hsync  in  1  horizontal sync, aligned with the renderer outputs
vsync  in  1  vertical sync, aligned with the renderer outputs
drawing  in  NSPR  drawing flag per sprite; bit i belongs to sprite i
pix  in  NSPR*SPR_DATAW  pixel indices; sprite i occupies [i*SPR_DATAW +: SPR_DATAW]
pal_we  in  1  palette write strobe
pal_addr  in  $clog2(NSPR)+SPR_DATAW  palette address {sprite, index}
pal_data  in  12  palette write data {R,G,B}
r  out  4  red
g  out  4  green
b  out  4  blue
de_o  out  1  de delayed by 2 cycles
hsync_o  out  1  hsync delayed by 2 cycles
vsync_o  out  1  vsync delayed by 2 cycles
coll  out  NSPR  collision flags for the previous frame; bit i = sprite 0 overlapped sprite i; bit 0 is always 0
coll_valid  out  1  1-cycle pulse when coll updates

Behaviour:
- Reset values: r, g, b, de_o, hsync_o, vsync_o, coll, coll_valid are all 0. Every palette entry resets to 12'h000. The collision accumulator resets to 0.
- Opacity: opaque[i] = drawing[i] && (pix_i != TRANSP_IDX).
- Stage 1 (registered):
  - hit = OR of opaque.
  - sel = lowest i with opaque[i].
  - idx = pix_sel.
  - de, hsync and vsync are delayed one cycle alongside.
- Stage 2 (registered):
  - When de_d1=0, RGB = 0.
  - Else when hit_d1=1, RGB = palette[{sel_d1, idx_d1}].
  - Else RGB = BG_COLR.
  - Sync and de complete a 2-cycle delay.
- Total latency from an input pixel to RGB is exactly 2 cycles. Timing outputs stay cycle-aligned with RGB.
- Palette:
  - Holds NSPR*2^SPR_DATAW entries of 12 bits.
  - Write is synchronous on pal_we.
  - A stage-2 read at the same address in the same cycle as a write returns the old value. The new value is visible from the next cycle.
  - pal_addr with sprite field >= NSPR: the write is ignored.
- Collision:
  - Each cycle with de=1, acc[i] |= opaque[0] && opaque[i], for i = 1..NSPR-1.
  - On frame: coll <= acc | current-cycle hits, acc <= 0, coll_valid=1 for one cycle. A hit coinciding with frame counts toward the closing frame.
  - Hits while de=0 are ignored.
- drawing=1 with pix==TRANSP_IDX is transparent. A lower-priority opaque sprite or the background shows through.
- Reset asserted mid-line: outputs are 0 on the next cycle. Pipeline contents and the accumulator are discarded. Palette contents are cleared.

Optional Feature:
- Macro: MIXER_COLL_STICKY_EN.
- Defined:
  - Adds input coll_clr (1 bit) and output coll_sticky (NSPR bits).
  - coll_sticky[i] sets on any counted collision with sprite i and holds until coll_clr.
  - coll_clr and a new hit in the same cycle: set wins.
  - Reset value is 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Background only: de=1, drawing=0 -> 2 cycles later RGB=1/3/7; de=0 -> RGB=0; hsync/vsync/de appear on the outputs exactly 2 cycles delayed.
- Priority: write pal[{0,5}]=12'hF00 and pal[{1,2}]=12'h0F0; drive drawing=4'b0011, pix0=5, pix1=2 -> RGB=F/0/0; then pix0=0 (transparent) -> RGB=0/F/0.
- Palette hazard: write pal[{1,2}]=12'hABC in the same cycle stage 2 reads that entry -> old colour is output; next pixel -> A/B/C.
- Collision: overlap sprite 0 and sprite 2 opaque for 3 pixels inside de, then pulse frame -> coll=4'b0100 with coll_valid=1 for 1 cycle; next frame with no overlap -> coll=0.
- Boundaries: overlap only while de=0 -> coll=0; overlap on the same cycle as frame -> the bit is reported in that frame's coll.
- Reset mid-line while sprites are drawing -> next cycle all outputs 0; pal[{0,5}] reads as 0 afterwards.
